// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin slave arbiters.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } arb_state_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first requester after ptr, wrapping modulo NCH.
module rr_pick #(
    parameter  int NCH = 4,
    localparam int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic           hit,
    output logic [SW-1:0]  idx
);

    // Scan from the farthest candidate to the nearest so the closest requester after ptr wins.
    always_comb begin
        int          cand_i;
        logic [SW-1:0] cand;
        hit    = 1'b0;
        idx    = '0;
        cand_i = 0;
        cand   = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand_i = (int'(ptr) + k) % NCH;
            cand   = SW'(cand_i);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_slave_arbiter.sv
// Merges NCH slave channel streams into one FIFO write port with round-robin
// grants, bounded bursts, and a global halt while the master reports completion.
//
// state | meaning
// IDLE  | no grant; picks the next valid channel after ptr (one bubble cycle)
// BUSY  | grant held; beats accepted while the FIFO has room and no halt
// HALT  | master completion active; all ready low, ptr kept
module rr_slave_arbiter
    import arb_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DW    = 32,
    parameter  int MW    = 2,
    parameter  int PW    = 8,
    parameter  int BURST = 4,
    localparam int SW    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mstr_cmplt,
    input  logic              fifo_full,
    input  logic [NCH-1:0]    slv_valid,
    input  logic [NCH*MW-1:0] slv_mode,
    input  logic [NCH*PW-1:0] slv_proc_valid,
    input  logic [NCH*DW-1:0] slv_data,
    output logic [NCH-1:0]    slv_ready,
    output logic              out_valid,
    output logic [MW-1:0]     out_mode,
    output logic [PW-1:0]     out_proc_val,
    output logic [DW-1:0]     out_data,
    output logic [SW-1:0]     out_src
);

    arb_state_t       state;
    logic [SW-1:0]    grant;
    logic [SW-1:0]    ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_hit;
    logic [SW-1:0]    pick_idx;

    logic             g_valid;
    logic [MW-1:0]    g_mode;
    logic [PW-1:0]    g_proc_val;
    logic [DW-1:0]    g_data;

    logic             open;
    logic             accept;
    logic             last_beat;

    rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .req (slv_valid),
        .ptr (ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    // Select the granted channel's valid and payload out of the packed buses.
    always_comb begin
        g_valid    = slv_valid[grant];
        g_mode     = slv_mode[int'(grant)*MW +: MW];
        g_proc_val = slv_proc_valid[int'(grant)*PW +: PW];
        g_data     = slv_data[int'(grant)*DW +: DW];
    end

    // Ready reacts to fifo_full and mstr_cmplt in the same cycle, so they stay out of the registers.
    always_comb begin
        open      = (state == BUSY) && !fifo_full && !mstr_cmplt;
        accept    = open && g_valid;
        last_beat = (beat_cnt == CNT_W'(BURST - 1));
        slv_ready = '0;
        if (open) begin
            slv_ready[grant] = 1'b1;
        end
    end

    // Grant FSM: arbitration, burst counting and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            ptr      <= SW'(NCH - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (mstr_cmplt) begin
                        state <= HALT;
                    end else if (pick_hit) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mstr_cmplt) begin
                        // ptr is left alone so the interrupted channel keeps its place.
                        state <= HALT;
                    end else if (!g_valid) begin
                        ptr   <= grant;
                        state <= IDLE;
                    end else if (!fifo_full) begin
                        if (last_beat) begin
                            ptr   <= grant;
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (!mstr_cmplt) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register: one FIFO write per accepted beat; payload holds between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_mode     <= '0;
            out_proc_val <= '0;
            out_data     <= '0;
            out_src      <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_mode     <= g_mode;
                out_proc_val <= g_proc_val;
                out_data     <= g_data;
                out_src      <= grant;
            end
        end
    end

endmodule

// File: tb/tb_rr_slave_arbiter.sv
// Self-checking bench for rr_slave_arbiter: directed scenarios plus a random soak,
// all checked against a behavioural owner/queue model of the arbitration rules.
module tb_rr_slave_arbiter;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int MW    = 2;
    localparam int PW    = 8;
    localparam int BURST = 4;
    localparam int SW    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mstr_cmplt;
    logic              fifo_full;
    logic [NCH-1:0]    slv_valid;
    logic [NCH*MW-1:0] slv_mode;
    logic [NCH*PW-1:0] slv_proc_valid;
    logic [NCH*DW-1:0] slv_data;
    logic [NCH-1:0]    slv_ready;
    logic              out_valid;
    logic [MW-1:0]     out_mode;
    logic [PW-1:0]     out_proc_val;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;

    rr_slave_arbiter #(
        .NCH   (NCH),
        .DW    (DW),
        .MW    (MW),
        .PW    (PW),
        .BURST (BURST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mstr_cmplt     (mstr_cmplt),
        .fifo_full      (fifo_full),
        .slv_valid      (slv_valid),
        .slv_mode       (slv_mode),
        .slv_proc_valid (slv_proc_valid),
        .slv_data       (slv_data),
        .slv_ready      (slv_ready),
        .out_valid      (out_valid),
        .out_mode       (out_mode),
        .out_proc_val   (out_proc_val),
        .out_data       (out_data),
        .out_src        (out_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-channel beat sequence numbers and data bases.
    int          seq  [NCH];
    logic [DW-1:0] base [NCH];

    // Model: owner = channel holding the grant (-1 none), cnt = beats in this grant,
    // last = channel served last (round-robin origin), halted = master completion phase.
    int            m_owner;
    int            m_cnt;
    int            m_last;
    bit            m_halt;
    logic          m_ov;
    logic [MW-1:0] m_mode;
    logic [PW-1:0] m_pv;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_src;

    logic [DW-1:0] wr_data[$];
    int            wr_src[$];
    int            wr_cyc[$];

    function automatic logic [DW-1:0] ch_data(int i);
        return base[i] + DW'(seq[i]);
    endfunction

    function automatic logic [MW-1:0] ch_mode(int i);
        return MW'(seq[i] + i);
    endfunction

    function automatic logic [PW-1:0] ch_pv(int i);
        return PW'(seq[i] * 3 + i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = NCH - 1;
        m_halt  = 1'b0;
        m_ov    = 1'b0;
        m_mode  = '0;
        m_pv    = '0;
        m_data  = '0;
        m_src   = '0;
    endtask

    function automatic logic [NCH-1:0] model_ready(input logic full, input logic cmplt);
        if (m_owner >= 0 && !m_halt && !full && !cmplt)
            return NCH'(1) << m_owner;
        return '0;
    endfunction

    // Advance the model across one rising edge with the inputs currently driven.
    task automatic model_step(input logic [NCH-1:0] v, input logic full, input logic cmplt);
        int  ch;
        bit  found;
        m_ov = 1'b0;
        if (m_halt) begin
            if (!cmplt) m_halt = 1'b0;
        end else if (m_owner < 0) begin
            if (cmplt) begin
                m_halt = 1'b1;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= NCH; k++) begin
                    ch = (m_last + k) % NCH;
                    if (!found && v[ch]) begin
                        found   = 1'b1;
                        m_owner = ch;
                        m_cnt   = 0;
                    end
                end
            end
        end else begin
            ch = m_owner;
            if (cmplt) begin
                m_halt  = 1'b1;
                m_owner = -1;
            end else if (!v[ch]) begin
                m_last  = ch;
                m_owner = -1;
            end else if (!full) begin
                m_ov   = 1'b1;
                m_data = ch_data(ch);
                m_mode = ch_mode(ch);
                m_pv   = ch_pv(ch);
                m_src  = SW'(ch);
                seq[ch]++;
                m_cnt++;
                if (m_cnt == BURST) begin
                    m_last  = ch;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic drive(input logic [NCH-1:0] v, input logic full, input logic cmplt);
        slv_valid  = v;
        fifo_full  = full;
        mstr_cmplt = cmplt;
        for (int i = 0; i < NCH; i++) begin
            slv_data[i*DW +: DW]       = ch_data(i);
            slv_mode[i*MW +: MW]       = ch_mode(i);
            slv_proc_valid[i*PW +: PW] = ch_pv(i);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},  64'(slv_ready),    64'd0);
        check({tag, "_ovalid"}, 64'(out_valid),    64'd0);
        check({tag, "_omode"},  64'(out_mode),     64'd0);
        check({tag, "_opv"},    64'(out_proc_val), 64'd0);
        check({tag, "_odata"},  64'(out_data),     64'd0);
        check({tag, "_osrc"},   64'(out_src),      64'd0);
    endtask

    // One clock cycle: entered just after a falling edge, leaves just after the next one.
    task automatic cycle(input logic [NCH-1:0] v, input logic full, input logic cmplt, input bit do_rst);
        drive(v, full, cmplt);
        #1;
        check("ready", 64'(slv_ready), 64'(model_ready(full, cmplt)));
        if (do_rst) begin
            #1 rst_n = 1'b0;
            #1 check_outputs_zero("async_rst");
            rst_n = 1'b1;
            model_reset();
        end
        model_step(v, full, cmplt);
        @(negedge clk);
        cyc++;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_data",  64'(out_data),  64'(m_data));
        check("out_mode",  64'(out_mode),  64'(m_mode));
        check("out_pv",    64'(out_proc_val), 64'(m_pv));
        check("out_src",   64'(out_src),   64'(m_src));
        if (out_valid) begin
            wr_data.push_back(out_data);
            wr_src.push_back(int'(out_src));
            wr_cyc.push_back(cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] v;
        int             s0;

        base[0] = 32'h1000_0000;
        base[1] = 32'h2000_0000;
        base[2] = 32'h0000_00A0;
        base[3] = 32'h4000_0000;
        for (int i = 0; i < NCH; i++) seq[i] = 0;
        model_reset();

        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Single channel 2 with six beats: 4-beat burst, bubble, then 2 beats.
        for (int k = 0; k < 14; k++) begin
            v = (seq[2] < 6) ? 4'b0100 : 4'b0000;
            cycle(v, 1'b0, 1'b0, 1'b0);
        end
        check("s1_count", 64'(wr_data.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < wr_data.size()) begin
                check("s1_data", 64'(wr_data[k]), 64'(32'hA0 + k));
                check("s1_src",  64'(wr_src[k]),  64'd2);
            end
        end
        if (wr_cyc.size() >= 5) begin
            check("s1_inburst_gap", 64'(wr_cyc[3] - wr_cyc[2]), 64'd1);
            check("s1_bubble_gap",  64'(wr_cyc[4] - wr_cyc[3]), 64'd2);
        end

        // Channel 1 with fifo_full held for three cycles mid-burst.
        for (int k = 0; k < 12; k++)
            cycle(4'b0010, (k >= 3 && k < 6), 1'b0, 1'b0);

        // Channel 3 burst interrupted by a two-cycle master completion.
        for (int k = 0; k < 14; k++) begin
            v = (k < 3) ? 4'b1000 : 4'b1111;
            cycle(v, 1'b0, (k == 3 || k == 4), 1'b0);
        end
        for (int k = 0; k < 6; k++) cycle('0, 1'b0, 1'b0, 1'b0);

        // Channel 0 drops valid after one beat while channel 1 keeps requesting.
        s0 = seq[0];
        for (int k = 0; k < 12; k++) begin
            v    = 4'b0010;
            v[0] = (seq[0] < s0 + 1);
            cycle(v, 1'b0, 1'b0, 1'b0);
        end

        // Async reset mid-burst, then all channels valid: bursts 0,1,2,3,0.
        for (int k = 0; k < 3; k++) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        wr_data.delete();
        wr_src.delete();
        wr_cyc.delete();
        cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 26; k++) cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        check("s6_count_min", 64'(wr_src.size() >= 17), 64'd1);
        for (int k = 0; k < 17; k++) begin
            if (k < wr_src.size()) begin
                check("s6_src", 64'(wr_src[k]), 64'((k / BURST) % NCH));
                if (k > 0)
                    check("s6_gap", 64'(wr_cyc[k] - wr_cyc[k-1]), (k % BURST == 0) ? 64'd2 : 64'd1);
            end
        end

        // Random soak.
        for (int k = 0; k < 3000; k++) begin
            v = NCH'($urandom) | NCH'($urandom);
            cycle(v, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 5), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_slave_arbiter.md
# rr_slave_arbiter

Parametrised N-channel arbiter. It merges streams from NCH slave processing channels into the single shared output FIFO in front of master 0. Channels are granted in round-robin order with bounded burst locking and explicit per-channel ready/valid handshakes. Each accepted beat is registered once and presented as a FIFO write with its source channel tag. All transfers halt while the master signals completion.

## Interface
- NCH, 4: number of slave channels (2..16)
- DW, 32: data width per beat
- MW, 2: mode field width
- PW, 8: proc_valid field width
- BURST, 4: maximum beats per grant before re-arbitration (1..255)
- SW, $clog2(NCH): source tag width (derived, not overridable)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- mstr_cmplt  in  1  master complete; blocks all acceptance while high
- fifo_full  in  1  output FIFO cannot take another write after the current cycle (almost-full semantics: high when ≤1 entry free)
- slv_valid  in  NCH  per-channel beat valid
- slv_mode  in  NCH*MW  packed per-channel mode; channel i at [i*MW +: MW]
- slv_proc_valid  in  NCH*PW  packed per-channel proc_valid
- slv_data  in  NCH*DW  packed per-channel data
- slv_ready  out  NCH  per-channel ready; at most one bit high
- out_valid  out  1  FIFO write strobe, one cycle per beat
- out_mode  out  MW  mode of the written beat
- out_proc_val  out  PW  proc_valid of the written beat
- out_data  out  DW  data of the written beat
- out_src  out  SW  index of the source channel

## Operation
- Beat transfer on channel i: slv_valid[i] && slv_ready[i] at the rising edge.
- slv_ready[i] = (state==BUSY) && (grant==i) && !fifo_full && !mstr_cmplt. It is combinational from registered state and the two live inputs.
- The block never drops or duplicates a beat. Beats from one grant are written in acceptance order.
- States:
  - IDLE: if mstr_cmplt, go to HALT. Else if any slv_valid, grant the first valid channel searching from ptr+1 upward with wrap modulo NCH. Set grant, set beat_cnt=0, go to BUSY. Else stay in IDLE.
  - BUSY:
    - mstr_cmplt: go to HALT.
    - A beat accepted with beat_cnt==BURST-1: set ptr=grant, go to IDLE.
    - A beat accepted otherwise: beat_cnt+1, stay in BUSY.
    - slv_valid[grant] low: set ptr=grant, go to IDLE; no beat is accepted.
    - fifo_full with slv_valid[grant] high: hold. Grant and count are kept.
  - HALT: all ready low. When mstr_cmplt is low, go to IDLE; ptr is preserved.
- Round-robin pointer ptr resets to NCH-1, so channel 0 has first priority after reset.
- Output register: on acceptance, load mode/proc_val/data/src from the granted channel and set out_valid=1 next cycle. Otherwise out_valid=0 next cycle and the payload holds its last value.
- beat_cnt is 8 bits and saturates by construction (BURST ≤255). It is cleared on every new grant.

## Timing
- Reset values: slv_ready=0, out_valid=0, out_mode=0, out_proc_val=0, out_data=0, out_src=0. Internally state=IDLE, grant=0, beat_cnt=0, ptr=NCH-1.
- Asynchronous reset mid-burst: outputs clear immediately, and any beat in the output register is discarded. Upstream channels must re-present their data.
- Arbitration latency: 1 cycle in IDLE before the first ready. A channel holding valid sees ready at cycle 2 after valid rises from IDLE.
- Throughput: 1 beat/cycle within a grant. There is one bubble cycle (IDLE) between grants.
- Acceptance-to-write latency: 1 cycle (out_valid the cycle after the handshake edge).
- fifo_full and mstr_cmplt take effect on ready in the same cycle. At most one write (the previous acceptance) follows their assertion.
- Simultaneous end of burst and mstr_cmplt: mstr_cmplt wins and the block goes to HALT. The beat is not accepted because ready is already low.
- Fairness bound: a continuously valid channel waits at most (NCH-1)*(BURST+1) cycles plus fifo_full/HALT cycles.

## Structure
- Package arb_pkg: typedef of the state enum (IDLE, BUSY, HALT) and localparam of the beat_cnt width (8).
- One sub-module, rr_pick: combinational, with inputs req[NCH] and ptr and outputs hit and idx. It is reused by future arbiters.
- Top module: FSM, counters, packed-slice muxing, output register.

## Test plan
- Reset then single channel: NCH=4, BURST=4, ch2 valid with data 0xA0..0xA5. Required: writes 0xA0..0xA3 with out_src=2, one idle cycle, then 0xA4,0xA5, then IDLE.
- All four channels continuously valid: the out_src sequence in bursts of 4 is 0,1,2,3,0. There is exactly one out_valid=0 cycle between bursts.
- fifo_full asserted for 3 cycles mid-burst on ch1: ready low for those 3 cycles, no beat lost or duplicated, and the burst resumes with the correct count (4 total).
- mstr_cmplt pulsed for 2 cycles during the ch3 burst after beat 2: HALT with no ready. On release, arbitration starts from ptr+1. The remaining ch3 beats are served later in round-robin order.
- Channel drops valid after 1 beat: grant is released, and the next valid channel gets ready 2 cycles later.
- Asynchronous rst_n pulse between clock edges mid-burst: all outputs go to 0 immediately. After release, ch0 has priority when all channels are valid.
